// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enable divider, h/v counters, registered sync/enable/start decodes
// and a frame counter over a parametrised active/porch/sync layout.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if ((H_TOTAL > (32'd1 << CW)) || (V_TOTAL > (32'd1 << CW))) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [DW-1:0] div_cnt;
    logic          started;
    logic          step;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          f_wrap;
    logic          hs_act;
    logic          vs_act;
    logic          de_nxt;

    assign step = pix_en & en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else if (en) begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end else begin
            pix_en  <= 1'b0;
        end
    end

    // Decodes are taken from the next count values so they land on the same edge as the counters.
    always_comb begin
        h_nxt  = hcount;
        v_nxt  = vcount;
        f_wrap = 1'b0;
        if (!started) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (hcount == H_LAST) begin
            h_nxt = '0;
            if (vcount == V_LAST) begin
                v_nxt  = '0;
                f_wrap = 1'b1;
            end else begin
                v_nxt = vcount + 1'b1;
            end
        end else begin
            h_nxt = hcount + 1'b1;
        end
        hs_act = (32'(h_nxt) >= HS_BEG) && (32'(h_nxt) < HS_END);
        vs_act = (32'(v_nxt) >= VS_BEG) && (32'(v_nxt) < VS_END);
        de_nxt = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started     <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (step) begin
            started     <= 1'b1;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            display_on  <= de_nxt;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            if (f_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x525 layout at CLK_DIV=2 and a tiny 8x6 layout
// at CLK_DIV=1, each checked against hand-derived timing.
module tb_vga_timing_gen;

    logic       clk;
    logic       reset_a, en_a, reset_b, en_b;
    logic       pix_en_a, hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a;
    logic [9:0] hcount_a, vcount_a;
    logic [7:0] frame_cnt_a;
    logic       pix_en_b, hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b;
    logic [3:0] hcount_b, vcount_b;
    logic [7:0] frame_cnt_b;

    int n_chk = 0;
    int n_err = 0;

    vga_timing_gen u_dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .pix_en(pix_en_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(display_on_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(4)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .pix_en(pix_en_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(display_on_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset 7 clk, release, and walk the divider up to the (0,0) pixel.
    task automatic restart_a(input string tag);
        reset_a = 1'b0;
        en_a    = 1'b1;
        repeat (7) tick();
        check({tag, "_rst_outs"}, 32'({pix_en_a, hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a}), 'b011000);
        check({tag, "_rst_cnt"}, 32'({hcount_a, vcount_a, frame_cnt_a}), 0);
        reset_a = 1'b1;
        tick();
        check({tag, "_e1"}, 32'({pix_en_a, frame_start_a, display_on_a}), 'b000);
        tick();
        check({tag, "_e2"}, 32'({pix_en_a, frame_start_a, display_on_a}), 'b100);
        tick();
        check({tag, "_e3"}, 32'({pix_en_a, display_on_a, line_start_a, frame_start_a, hsync_a}), 'b01111);
        check({tag, "_e3_cnt"}, 32'({hcount_a, vcount_a, frame_cnt_a}), 0);
    endtask

    initial begin
        int h, v;
        int ea_cnt, ea_pe, ea_dec;
        int hs_low, hs_first, hs_last, de_cyc, de_off_first, ls_t0, ls_t1, ls_cyc, vs_low;
        logic ls_prev;
        int frz_err;
        int eb_cnt, eb_dec, eb_fc, eb_pe, n_fs;
        logic [7:0] fc255, fc256;

        reset_a = 1'b0; en_a = 1'b1;
        reset_b = 1'b0; en_b = 1'b1;
        ea_cnt = 0; ea_pe = 0; ea_dec = 0;
        hs_low = 0; hs_first = -1; hs_last = -1; de_cyc = 0; de_off_first = -1;
        ls_t0 = -1; ls_t1 = -1; ls_cyc = 0; vs_low = 0; ls_prev = 1'b0;
        frz_err = 0;
        eb_cnt = 0; eb_dec = 0; eb_fc = 0; eb_pe = 0; n_fs = 0;
        fc255 = '0; fc256 = '0;

        restart_a("start");

        // t=0 is the first cycle of pixel (0,0); each pixel lasts 2 clk.
        for (int t = 0; t < 3800; t++) begin
            h = (t / 2) % 800;
            v = t / 1600;
            if (32'(hcount_a) !== 32'(h) || 32'(vcount_a) !== 32'(v)) ea_cnt++;
            if (pix_en_a !== (t % 2 == 1)) ea_pe++;
            if (hsync_a !== !(h >= 656 && h < 752)) ea_dec++;
            if (vsync_a !== 1'b1) ea_dec++;
            if (display_on_a !== (h < 640)) ea_dec++;
            if (line_start_a !== (h == 0)) ea_dec++;
            if (frame_start_a !== (h == 0 && v == 0)) ea_dec++;
            if (t < 3200) begin
                if (hsync_a == 1'b0) begin
                    hs_low++;
                    if (t < 1600) begin
                        if (hs_first < 0) hs_first = h;
                        hs_last = h;
                    end
                end
                if (display_on_a) de_cyc++;
                else if (t < 1600 && de_off_first < 0) de_off_first = h;
                if (line_start_a && !ls_prev) begin
                    if (ls_t0 < 0) ls_t0 = t;
                    else if (ls_t1 < 0) ls_t1 = t;
                end
                if (line_start_a) ls_cyc++;
                ls_prev = line_start_a;
                if (vsync_a == 1'b0) vs_low++;
            end
            tick();
        end
        check("a_counts", 32'(ea_cnt), 0);
        check("a_pix_en", 32'(ea_pe), 0);
        check("a_decode", 32'(ea_dec), 0);
        check("a_hs_low_clk", 32'(hs_low), 384);
        check("a_hs_first", 32'(hs_first), 656);
        check("a_hs_last", 32'(hs_last), 751);
        check("a_de_clk", 32'(de_cyc), 2560);
        check("a_de_off_at", 32'(de_off_first), 640);
        check("a_ls_period", 32'(ls_t1 - ls_t0), 1600);
        check("a_ls_clk", 32'(ls_cyc), 4);
        check("a_vs_low", 32'(vs_low), 0);

        check("frz_pre", 32'({hcount_a, vcount_a, pix_en_a}), {10'd300, 10'd2, 1'b0});
        en_a = 1'b0;
        repeat (10) begin
            tick();
            if (hcount_a !== 10'd300 || vcount_a !== 10'd2 || pix_en_a !== 1'b0 ||
                hsync_a !== 1'b1 || vsync_a !== 1'b1 || display_on_a !== 1'b1 ||
                line_start_a !== 1'b0 || frame_start_a !== 1'b0) frz_err++;
        end
        check("frz_hold", 32'(frz_err), 0);
        en_a = 1'b1;
        tick();
        check("frz_res1", 32'({pix_en_a, hcount_a}), {1'b1, 10'd300});
        tick();
        check("frz_res2", 32'({pix_en_a, hcount_a}), {1'b0, 10'd301});
        tick();
        check("frz_res3", 32'({pix_en_a, hcount_a}), {1'b1, 10'd301});
        tick();
        check("frz_res4", 32'({pix_en_a, hcount_a}), {1'b0, 10'd302});

        reset_a = 1'b0;
        #1;
        check("a_async_outs", 32'({pix_en_a, hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a}), 'b011000);
        check("a_async_cnt", 32'({hcount_a, vcount_a}), 0);
        restart_a("rst2");
        tick();
        tick();
        check("rst2_adv", 32'({hcount_a, vcount_a, frame_start_a}), {10'd1, 10'd0, 1'b0});

        reset_b = 1'b1;
        tick();
        check("b_e1", 32'({pix_en_b, frame_start_b, hcount_b}), {1'b1, 1'b0, 4'd0});
        tick();
        for (int s = 0; s <= 12480; s++) begin
            h = s % 8;
            v = (s / 8) % 6;
            if (32'(hcount_b) !== 32'(h) || 32'(vcount_b) !== 32'(v)) eb_cnt++;
            if (pix_en_b !== 1'b1) eb_pe++;
            if (hsync_b !== (h == 5 || h == 6)) eb_dec++;
            if (vsync_b !== (v == 4)) eb_dec++;
            if (display_on_b !== (h < 4 && v < 3)) eb_dec++;
            if (line_start_b !== (h == 0)) eb_dec++;
            if (frame_start_b !== (h == 0 && v == 0)) eb_dec++;
            if (32'(frame_cnt_b) !== 32'((s / 48) % 256)) eb_fc++;
            if (frame_start_b) n_fs++;
            if (s == 255 * 48) fc255 = frame_cnt_b;
            if (s == 256 * 48) fc256 = frame_cnt_b;
            if (s < 12480) tick();
        end
        check("b_counts", 32'(eb_cnt), 0);
        check("b_pix_en", 32'(eb_pe), 0);
        check("b_decode", 32'(eb_dec), 0);
        check("b_frame_cnt", 32'(eb_fc), 0);
        check("b_fs_count", 32'(n_fs), 261);
        check("b_fc_255", 32'(fc255), 255);
        check("b_fc_wrap", 32'(fc256), 0);
        repeat (19) tick();
        check("b_mid", 32'({hcount_b, vcount_b, frame_cnt_b}), {4'd3, 4'd2, 8'd4});
        reset_b = 1'b0;
        #1;
        check("b_async_outs", 32'({pix_en_b, hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b}), 'b000000);
        check("b_async_cnt", 32'({hcount_b, vcount_b, frame_cnt_b}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
